flush_ctrl: RTL
===============

FLUSH_CTRL -- requirements
Module: flush_ctrl

Interface
REQ-001 Parameter: none; outstanding-fetch capacity SHALL be fixed at 3 (2-bit counter).
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 wb_ex  input  1  exception commit from WB, already qualified by WB valid.
REQ-005 wb_tlbr  input  1  exception is a TLB refill; meaningful only with wb_ex.
REQ-006 ertn_flush  input  1  ERTN commit from WB.
REQ-007 wb_refetch_flush  input  1  refetch request from WB (TLB/CSR side-effect instructions).
REQ-008 wb_pc  input  32  PC of the committing WB instruction.
REQ-009 csr_eentry, csr_tlbrentry, csr_era  input  32 each  current CSR values.
REQ-010 inst_req_fire  input  1  IF instruction-read address handshake completed this cycle.
REQ-011 inst_resp_fire  input  1  IF instruction-read data beat (last) accepted this cycle.
REQ-012 redirect_ready  input  1  IF accepts the redirect this cycle.
REQ-013 flush_all  output  1  one-cycle pulse; clears valid in IF/ID/EX/MEM.
REQ-014 redirect_valid  output  1  redirect target pending for IF.
REQ-015 redirect_pc  output  32  redirect target.
REQ-016 fetch_block  output  1  IF SHALL NOT issue new instruction reads while high.
REQ-017 discard_resp  output  1  current inst_resp_fire belongs to a flushed fetch; IF drops it.

Function
REQ-018 States: IDLE, DRAIN, REDIRECT; encoding free.
REQ-019 Event = wb_ex | ertn_flush | wb_refetch_flush, recognised only in IDLE; ignored in DRAIN/REDIRECT.
REQ-020 Priority on simultaneous events: wb_ex > ertn_flush > wb_refetch_flush.
REQ-021 Target: wb_ex&wb_tlbr -> csr_tlbrentry; wb_ex&~wb_tlbr -> csr_eentry; ertn -> csr_era; refetch -> wb_pc+4 (32-bit wrap, 0xFFFFFFFC+4 = 0).
REQ-022 Target SHALL be sampled in the event cycle into redirect_pc and held until redirect handshake.
REQ-023 flush_all SHALL be combinational: high exactly in the IDLE event cycle, zero latency.
REQ-024 Outstanding counter cnt: +1 on inst_req_fire only, -1 on inst_resp_fire only, unchanged when both or neither; updated in every state.
REQ-025 fetch_block = (state != IDLE) | (cnt == 3); cnt SHALL saturate at 3 and not underflow below 0.
REQ-026 Event cycle next state: cnt_next != 0 -> DRAIN; else -> REDIRECT. A req_fire in the event cycle counts toward the drain.
REQ-027 DRAIN: discard_resp = inst_resp_fire; exit to REDIRECT in the cycle after cnt reaches 0.
REQ-028 discard_resp SHALL be 0 in IDLE and REDIRECT.
REQ-029 REDIRECT: redirect_valid = 1; on redirect_ready -> IDLE next cycle, redirect_valid low that cycle.
REQ-030 redirect_valid SHALL be 0 in IDLE and DRAIN; redirect_pc value outside REDIRECT is don't-care but held.
REQ-031 Minimum event-to-redirect latency: 1 cycle (event in cycle N, redirect_valid in N+1).

Reset
REQ-032 On resetn low at posedge: state IDLE, cnt 0, redirect_pc 0; flush_all, redirect_valid, fetch_block, discard_resp all 0 (flush_all not driven by inputs while resetn low).
REQ-033 Reset mid-DRAIN or mid-REDIRECT SHALL abandon the pending redirect with no further outputs.

Verification
REQ-034 cnt=0, wb_ex=1, wb_tlbr=0, eentry=0x1C008000 -> flush_all pulse cycle N; redirect_valid=1, pc=0x1C008000 in N+1; ready in N+1 -> IDLE in N+2.
REQ-035 cnt=2, ertn_flush=1, era=0x1C000120 -> DRAIN, fetch_block=1; two resp_fire each with discard_resp=1; REDIRECT to 0x1C000120 after cnt=0.
REQ-036 wb_ex, ertn_flush, wb_refetch_flush all high, wb_tlbr=1, tlbrentry=0x1C00F000 -> single flush_all, redirect_pc=0x1C00F000.
REQ-037 refetch with wb_pc=0x1C0001FC and req_fire same cycle, cnt=0 -> cnt=1, DRAIN, one discarded response, redirect_pc=0x1C000200; redirect_ready held low 5 cycles -> redirect_valid held 5 cycles, second event ignored.
REQ-038 cnt=3 with req_fire asserted -> fetch_block=1, cnt stays 3; resetn low during DRAIN -> all outputs 0, cnt 0 next cycle.

Source files
------------

// File: rtl/flush_ctrl.sv
// Pipeline flush / redirect controller.
// On an exception, ERTN or refetch commit from WB it pulses flush_all,
// waits for in-flight instruction fetches to drain, then presents the
// redirect target to IF until IF accepts it.
module flush_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_ex,
  input  logic        wb_tlbr,
  input  logic        ertn_flush,
  input  logic        wb_refetch_flush,
  input  logic [31:0] wb_pc,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_tlbrentry,
  input  logic [31:0] csr_era,
  input  logic        inst_req_fire,
  input  logic        inst_resp_fire,
  input  logic        redirect_ready,
  output logic        flush_all,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        fetch_block,
  output logic        discard_resp
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [1:0] CNT_MAX = 2'd3;

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic        evt;
  logic [31:0] tgt;

  // Outstanding-fetch count, saturating at both ends; a simultaneous
  // request and response cancel out.
  always_comb begin
    cnt_nxt = cnt;
    if (inst_req_fire && !inst_resp_fire && cnt != CNT_MAX)
      cnt_nxt = cnt + 2'd1;
    else if (inst_resp_fire && !inst_req_fire && cnt != 2'd0)
      cnt_nxt = cnt - 2'd1;
  end

  // Flush events are only honoured while idle, and never during reset.
  assign evt = resetn && (state == IDLE) &&
               (wb_ex || ertn_flush || wb_refetch_flush);

  // Redirect target, priority exception > ERTN > refetch.
  always_comb begin
    tgt = wb_pc + 32'd4;
    if (wb_ex)
      tgt = wb_tlbr ? csr_tlbrentry : csr_eentry;
    else if (ertn_flush)
      tgt = csr_era;
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt      = state;
    flush_all      = 1'b0;
    redirect_valid = 1'b0;
    discard_resp   = 1'b0;
    case (state)
      IDLE: begin
        flush_all = evt;
        if (evt)
          state_nxt = (cnt_nxt != 2'd0) ? DRAIN : REDIRECT;
      end
      DRAIN: begin
        // Responses still in flight belong to the squashed path.
        discard_resp = inst_resp_fire;
        if (cnt_nxt == 2'd0)
          state_nxt = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        if (redirect_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fetch_block = (state != IDLE) || (cnt == CNT_MAX);

  // State, counter and captured target registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      redirect_pc <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (evt)
        redirect_pc <= tgt;
    end
  end

endmodule
